// File: rtl/cardinal_nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_pkg
// Description : Shared definitions for the virtual-channel cardinal NIC:
//               processor-side register addresses, status-word bit positions
//               and the default packet width.
// Revision    : 1.0 - initial release
// ============================================================================
package cardinal_nic_pkg;

    // Default packet / register width.
    localparam int DEFAULT_DATA_W = 64;

    // Processor-side register map (2-bit address).
    typedef enum logic [1:0] {
        ADDR_IN_DATA  = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_DATA = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } nic_addr_e;

    // Bit positions in the numeric value of the status words.
    // IN_STAT : [0] non-empty, [n:1] input count.
    // OUT_STAT: [0] VC0 full, [1] VC1 full, [2] sticky overflow.
    localparam int NONEMPTY_BIT = 0;
    localparam int FULL0_BIT    = 0;
    localparam int FULL1_BIT    = 1;
    localparam int OVF_BIT      = 2;

endpackage : cardinal_nic_pkg
`default_nettype wire

// File: rtl/cardinal_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_fifo
// Description : Synchronous FIFO with arbitrary depth (>= 1). The head entry
//               is presented combinationally on dout. Pushes when full and
//               pops when empty are ignored. Push and pop in the same cycle
//               are both honoured (no bypass into an empty FIFO).
// Ports       : clk, reset (async, active-low)
//               push, din   - write request / data
//               pop, dout   - read request / head data
//               count       - current occupancy
//               full, empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [0:WIDTH-1]             din,
    output logic [0:WIDTH-1]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [0:WIDTH-1] mem_q [DEPTH];
    logic [0:WIDTH-1] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : cardinal_fifo
`default_nettype wire

// File: rtl/cardinal_nic_vc.sv
`default_nettype none
// ============================================================================
// Module      : cardinal_nic_vc
// Description : Cardinal NIC with an input FIFO and two per-virtual-channel
//               output FIFOs. Sits between a cardinal processor and its ring
//               stop. Holds the register decode, the sticky overflow flag and
//               the polarity-driven injection mux.
// Ports       : clk, reset (async, active-low)
//               addr/d_in/d_out/nicEn/nicWrEn - processor register port
//               net_si/net_ri/net_di          - ring -> NIC
//               net_so/net_ro/net_do          - NIC -> ring
//               net_polarity                  - current ring polarity
// Revision    : 1.0 - initial release
// ============================================================================
module cardinal_nic_vc
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int VC_BIT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);

    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    // Input FIFO
    logic              in_push, in_pop, in_full, in_empty;
    logic [0:DATA_W-1] in_dout;
    logic [IN_CW-1:0]  in_count;

    // Output VC FIFOs
    logic              out0_push, out0_pop, out0_full, out0_empty;
    logic              out1_push, out1_pop, out1_full, out1_empty;
    logic [0:DATA_W-1] out0_dout, out1_dout;
    logic [OUT_CW-1:0] out0_count, out1_count;

    // Decode / flag
    logic              rd_en, wr_en;
    logic              out_wr, vc_sel, out_reject, stat_rd;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] stat_num;

    assign rd_en = nicEn && !nicWrEn;
    assign wr_en = nicEn && nicWrEn;

    // Ring receive side.
    assign net_ri  = reset && !in_full;
    assign in_push = net_si && net_ri;
    assign in_pop  = rd_en && (addr == ADDR_IN_DATA) && !in_empty;

    // Processor write into the VC queue chosen by the packet's VC bit; the
    // legality test uses the pre-edge count, so a same-cycle injection pop
    // never makes room for the write.
    assign vc_sel     = d_in[VC_BIT];
    assign out_wr     = wr_en && (addr == ADDR_OUT_DATA);
    assign out0_push  = out_wr && !vc_sel && (out0_count < OUT_CW'(OUT_DEPTH));
    assign out1_push  = out_wr &&  vc_sel && (out1_count < OUT_CW'(OUT_DEPTH));
    assign out_reject = out_wr && !(out0_push || out1_push);
    assign stat_rd    = rd_en && (addr == ADDR_OUT_STAT);

    // Injection: only the queue matching the current polarity may send.
    // Gating with reset makes net_so fall asynchronously.
    always_comb begin
        net_so   = 1'b0;
        net_do   = '0;
        out0_pop = 1'b0;
        out1_pop = 1'b0;
        if (reset && net_ro) begin
            if (net_polarity) begin
                net_so   = !out1_empty;
                out1_pop = !out1_empty;
                if (!out1_empty) begin
                    net_do = out1_dout;
                end
            end else begin
                net_so   = !out0_empty;
                out0_pop = !out0_empty;
                if (!out0_empty) begin
                    net_do = out0_dout;
                end
            end
        end
    end

    // Sticky overflow: an OUT_STAT read clears it, a rejected write sets it,
    // and the set has priority.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_rd) begin
            ovf_d = 1'b0;
        end
        if (out_reject) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Processor read mux. Status words are built as numeric values in a
    // descending vector and then copied MSB-aligned onto d_out.
    always_comb begin
        d_out    = '0;
        stat_num = '0;
        if (reset && rd_en) begin
            case (addr)
                ADDR_IN_DATA: begin
                    if (!in_empty) begin
                        d_out = in_dout;
                    end
                end
                ADDR_IN_STAT: begin
                    stat_num[IN_CW:1]         = in_count;
                    stat_num[NONEMPTY_BIT]    = !in_empty;
                    d_out                     = stat_num;
                end
                ADDR_OUT_STAT: begin
                    stat_num[OVF_BIT]   = ovf_q;
                    stat_num[FULL1_BIT] = out1_full;
                    stat_num[FULL0_BIT] = out0_full;
                    d_out               = stat_num;
                end
                default: d_out = '0;
            endcase
        end
    end

    cardinal_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .pop   (in_pop),
        .din   (net_di),
        .dout  (in_dout),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    cardinal_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out0_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out0_push),
        .pop   (out0_pop),
        .din   (d_in),
        .dout  (out0_dout),
        .count (out0_count),
        .full  (out0_full),
        .empty (out0_empty)
    );

    cardinal_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out1_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out1_push),
        .pop   (out1_pop),
        .din   (d_in),
        .dout  (out1_dout),
        .count (out1_count),
        .full  (out1_full),
        .empty (out1_empty)
    );

endmodule : cardinal_nic_vc
`default_nettype wire

// File: tb/tb_cardinal_nic_vc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cardinal_nic_vc
// Description : Directed self-checking bench for cardinal_nic_vc with default
//               parameters (DATA_W 64, depths 4, VC bit 0 = MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic_vc;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cardinal_nic_vc dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle register read; value sampled mid-cycle before the edge.
    task automatic rd_reg(input logic [1:0] a, output logic [63:0] val);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        #1;
        val = d_out;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic wr_out(input logic [63:0] val);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = val;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        reset = 1'b0; net_si = 1'b1; net_di = 64'h1234; net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
        tick(); tick();
        checks++;
        if (net_ri !== 1'b0) begin errors++; $display("FAIL reset_ri: got %b want 0", net_ri); end
        checks++;
        if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b want 0", net_so); end
        checks++;
        if (d_out !== 64'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", d_out); end
        net_si = 1'b0; nicEn = 1'b0; net_ro = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (net_ri !== 1'b1) begin errors++; $display("FAIL release_ri: got %b want 1", net_ri); end
        rd_reg(2'b01, v);
        checks++;
        if (v !== 64'h0) begin errors++; $display("FAIL release_in_stat: got %h want 0", v); end
    endtask

    task automatic test_input_fill();
        logic [63:0] v;
        net_si = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            net_di = 64'(i);
            #1;
            checks++;
            if (net_ri !== (i <= 4)) begin
                errors++; $display("FAIL fill_ri[%0d]: got %b want %b", i, net_ri, (i <= 4));
            end
            if (i <= 4) tick();
        end
        net_si = 1'b0;
        rd_reg(2'b01, v);
        checks++;
        if (v !== 64'd9) begin errors++; $display("FAIL fill_in_stat: got %h want 9", v); end
        for (int i = 1; i <= 4; i++) begin
            rd_reg(2'b00, v);
            checks++;
            if (v !== 64'(i)) begin errors++; $display("FAIL fill_in_data[%0d]: got %h want %h", i, v, i); end
        end
        rd_reg(2'b01, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL drained_in_stat: got %h want 0", v); end
        rd_reg(2'b00, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL empty_in_data: got %h want 0", v); end
    endtask

    task automatic test_vc_isolation();
        net_ro = 1'b0; net_polarity = 1'b0;
        wr_out(64'h8000_0000_0000_00AA);
        wr_out(64'h0000_0000_0000_00BB);
        net_ro = 1'b1;
        #1;
        checks++;
        if (net_so !== 1'b1 || net_do !== 64'hBB) begin
            errors++; $display("FAIL vc0_inject: so=%b do=%h want so=1 do=bb", net_so, net_do);
        end
        tick();
        checks++;
        if (net_so !== 1'b0 || net_do !== 64'h0) begin
            errors++; $display("FAIL vc1_blocked: so=%b do=%h want so=0 do=0", net_so, net_do);
        end
        net_polarity = 1'b1;
        #1;
        checks++;
        if (net_so !== 1'b1 || net_do !== 64'h8000_0000_0000_00AA) begin
            errors++; $display("FAIL vc1_inject: so=%b do=%h want so=1 do=80000000000000aa", net_so, net_do);
        end
        tick();
        checks++;
        if (net_so !== 1'b0) begin errors++; $display("FAIL vc1_drained: so=%b want 0", net_so); end
        net_ro = 1'b0; net_polarity = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b0;
        for (int i = 0; i < 5; i++) wr_out(64'h10 + 64'(i));
        rd_reg(2'b11, v);
        checks++;
        if (v !== 64'd5) begin errors++; $display("FAIL ovf_stat: got %h want 5", v); end
        rd_reg(2'b11, v);
        checks++;
        if (v !== 64'd1) begin errors++; $display("FAIL ovf_cleared: got %h want 1", v); end
        net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (net_so !== 1'b1 || net_do !== 64'h10 + 64'(i)) begin
                errors++; $display("FAIL ovf_drain[%0d]: so=%b do=%h want so=1 do=%h", i, net_so, net_do, 64'h10 + 64'(i));
            end
            tick();
        end
        checks++;
        if (net_so !== 1'b0) begin errors++; $display("FAIL ovf_dropped: so=%b want 0", net_so); end
        net_ro = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b0;
        for (int i = 0; i < 4; i++) wr_out(64'h20 + 64'(i));
        net_ro = 1'b1;
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h24;
        #1;
        checks++;
        if (net_so !== 1'b1 || net_do !== 64'h20) begin
            errors++; $display("FAIL simul_inject: so=%b do=%h want so=1 do=20", net_so, net_do);
        end
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0;
        rd_reg(2'b11, v);
        checks++;
        if (v !== 64'd4) begin errors++; $display("FAIL simul_stat: got %h want 4", v); end
        net_ro = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if (net_so !== 1'b1 || net_do !== 64'h20 + 64'(i)) begin
                errors++; $display("FAIL simul_drain[%0d]: so=%b do=%h want so=1 do=%h", i, net_so, net_do, 64'h20 + 64'(i));
            end
            tick();
        end
        checks++;
        if (net_so !== 1'b0) begin errors++; $display("FAIL simul_count3: so=%b want 0", net_so); end
        net_ro = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        net_si = 1'b1; net_di = 64'h31;
        tick();
        net_di = 64'h32;
        rd_reg(2'b00, v);
        net_si = 1'b0;
        checks++;
        if (v !== 64'h31) begin errors++; $display("FAIL b2b_pop: got %h want 31", v); end
        rd_reg(2'b01, v);
        checks++;
        if (v !== 64'd3) begin errors++; $display("FAIL b2b_stat: got %h want 3", v); end
        rd_reg(2'b00, v);
        checks++;
        if (v !== 64'h32) begin errors++; $display("FAIL b2b_second: got %h want 32", v); end
    endtask

    task automatic test_midstream_reset();
        logic [63:0] v;
        net_ro = 1'b0; net_polarity = 1'b1;
        net_si = 1'b1; net_di = 64'h55;
        tick();
        net_si = 1'b0;
        for (int i = 0; i < 5; i++) wr_out(64'h40 + 64'(i));
        wr_out(64'h8000_0000_0000_0077);
        net_ro = 1'b1;
        #1;
        checks++;
        if (net_so !== 1'b1) begin errors++; $display("FAIL pre_reset_so: got %b want 1", net_so); end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (net_so !== 1'b0 || net_do !== 64'h0) begin
            errors++; $display("FAIL async_reset_so: so=%b do=%h want so=0 do=0", net_so, net_do);
        end
        tick();
        reset = 1'b1; net_ro = 1'b0;
        rd_reg(2'b01, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL post_reset_in_stat: got %h want 0", v); end
        rd_reg(2'b11, v);
        checks++;
        if (v !== 64'd0) begin errors++; $display("FAIL post_reset_out_stat: got %h want 0", v); end
        net_ro = 1'b1;
        #1;
        checks++;
        if (net_so !== 1'b0) begin errors++; $display("FAIL post_reset_so: got %b want 0", net_so); end
        net_ro = 1'b0;
    endtask

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        test_reset();
        test_input_fill();
        test_vc_isolation();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cardinal_nic_vc
`default_nettype wire
